// File: rtl/weight_compressor_if.sv
// Dense tagged weight stream from the loader into weight_compressor.
// The loader drives the element fields; the compressor returns o_ready.
interface weight_compressor_if #(
   parameter int unsigned R_BW = 4,
   parameter int unsigned K_BW = 4
);
   logic            i_valid;
   logic            i_last;
   logic            i_nz;
   logic [R_BW-1:0] i_r;
   logic [K_BW-1:0] i_k;
   logic            o_ready;

   modport master (output i_valid, i_last, i_nz, i_r, i_k, input o_ready);
   modport slave  (input  i_valid, i_last, i_nz, i_r, i_k, output o_ready);
endinterface

// File: rtl/weight_compressor.sv
// Encodes a dense tagged weight stream into row/channel/pointer group tables.
// Optional macro WCOMP_KEEP_EMPTY_EN emits groups that contain no nonzeros.
`ifndef W_R_BITWIDTH
`define W_R_BITWIDTH 4
`endif
`ifndef W_K_BITWIDTH
`define W_K_BITWIDTH 4
`endif
`ifndef W_POS_PTR_BITWIDTH
`define W_POS_PTR_BITWIDTH 4
`endif
`ifndef W_R_LENGTH
`define W_R_LENGTH 8
`endif
`ifndef W_C_LENGTH
`define W_C_LENGTH 16
`endif

module weight_compressor #(
   parameter int unsigned R_BW   = `W_R_BITWIDTH,
   parameter int unsigned K_BW   = `W_K_BITWIDTH,
   parameter int unsigned PTR_BW = `W_POS_PTR_BITWIDTH,
   parameter int unsigned R_LEN  = `W_R_LENGTH,
   parameter int unsigned C_LEN  = `W_C_LENGTH
) (
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   input  logic                         i_start,
   weight_compressor_if.slave           s_if,
   output logic [R_BW-1:0]              o_r      [R_LEN],
   output logic [K_BW-1:0]              o_k      [R_LEN],
   output logic [PTR_BW:0]              o_ptr    [R_LEN],
   output logic [$clog2(C_LEN):0]       o_length,
   output logic [$clog2(R_LEN):0]       o_groups,
   output logic                         o_overflow,
   output logic                         o_finish
);

   localparam int unsigned LEN_W = $clog2(C_LEN) + 1;
   localparam int unsigned G_W   = $clog2(R_LEN) + 1;
   localparam int unsigned IDX_W = $clog2(R_LEN);
   localparam int unsigned P_W   = PTR_BW + 1;
   localparam logic [G_W-1:0]   G_MAX   = G_W'(R_LEN - 1);
   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(C_LEN);

`ifdef WCOMP_KEEP_EMPTY_EN
   localparam bit KEEP_EMPTY = 1'b1;
`else
   localparam bit KEEP_EMPTY = 1'b0;
`endif

   typedef enum logic {S_IDLE, S_COLLECT} state_t;

   state_t            state_q, state_d;
   logic              ready_q, ready_d;
   logic              finish_q, finish_d;
   logic              ovf_q, ovf_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  cnt_q, cnt_d;
   logic [G_W-1:0]    g_q, g_d;
   logic              cur_ok_q, cur_ok_d;
   logic [R_BW-1:0]   cur_r_q, cur_r_d;
   logic [K_BW-1:0]   cur_k_q, cur_k_d;
   logic [R_BW-1:0]   r_q   [R_LEN];
   logic [R_BW-1:0]   r_d   [R_LEN];
   logic [K_BW-1:0]   k_q   [R_LEN];
   logic [K_BW-1:0]   k_d   [R_LEN];
   logic [P_W-1:0]    ptr_q [R_LEN];
   logic [P_W-1:0]    ptr_d [R_LEN];

   logic accept;
   logic tag_chg;

   // ready_q is high exactly while collecting, so it doubles as the state qualifier
   assign accept  = s_if.i_valid && ready_q;
   assign tag_chg = cur_ok_q && ((s_if.i_r != cur_r_q) || (s_if.i_k != cur_k_q));

   // FSM state register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   // FSM next-state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (i_start) state_d = S_COLLECT;
         S_COLLECT: begin
            if (i_start)                      state_d = S_COLLECT;
            else if (accept && s_if.i_last)   state_d = S_IDLE;
         end
         default:   state_d = S_IDLE;
      endcase
   end

   // FSM outputs; a restart suppresses the finish of the discarded run
   always_comb begin
      ready_d  = 1'b0;
      finish_d = 1'b0;
      ready_d  = (state_d == S_COLLECT);
      finish_d = (state_q == S_COLLECT) && !i_start && accept && s_if.i_last;
   end

   // Table datapath: up to two group closes (tag change, then last) per element
   always_comb begin
      r_d      = r_q;
      k_d      = k_q;
      ptr_d    = ptr_q;
      len_d    = len_q;
      cnt_d    = cnt_q;
      g_d      = g_q;
      ovf_d    = ovf_q;
      cur_ok_d = cur_ok_q;
      cur_r_d  = cur_r_q;
      cur_k_d  = cur_k_q;
      if (i_start) begin
         for (int unsigned i = 0; i < R_LEN; i++) begin
            r_d[i]   = '0;
            k_d[i]   = '0;
            ptr_d[i] = '0;
         end
         len_d    = '0;
         cnt_d    = '0;
         g_d      = '0;
         ovf_d    = 1'b0;
         cur_ok_d = 1'b0;
      end else if (accept) begin
         if (tag_chg && (KEEP_EMPTY || (cnt_q != '0))) begin
            if (g_d == G_MAX) begin
               ovf_d = 1'b1;
            end else begin
               r_d[IDX_W'(g_d)]          = cur_r_q;
               k_d[IDX_W'(g_d)]          = cur_k_q;
               ptr_d[IDX_W'(g_d + 1'b1)] = P_W'(len_d);
               g_d                       = g_d + 1'b1;
            end
         end
         if (!cur_ok_q || tag_chg) cnt_d = '0;
         cur_r_d  = s_if.i_r;
         cur_k_d  = s_if.i_k;
         cur_ok_d = 1'b1;
         if (s_if.i_nz) begin
            if (len_d == LEN_MAX) begin
               ovf_d = 1'b1;
            end else begin
               len_d = len_d + 1'b1;
               cnt_d = cnt_d + 1'b1;
            end
         end
         if (s_if.i_last && (KEEP_EMPTY || (cnt_d != '0))) begin
            if (g_d == G_MAX) begin
               ovf_d = 1'b1;
            end else begin
               r_d[IDX_W'(g_d)]          = cur_r_d;
               k_d[IDX_W'(g_d)]          = cur_k_d;
               ptr_d[IDX_W'(g_d + 1'b1)] = P_W'(len_d);
               g_d                       = g_d + 1'b1;
            end
         end
      end
   end

   // Datapath and output registers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ready_q  <= 1'b0;
         finish_q <= 1'b0;
         ovf_q    <= 1'b0;
         len_q    <= '0;
         cnt_q    <= '0;
         g_q      <= '0;
         cur_ok_q <= 1'b0;
         cur_r_q  <= '0;
         cur_k_q  <= '0;
         for (int unsigned i = 0; i < R_LEN; i++) begin
            r_q[i]   <= '0;
            k_q[i]   <= '0;
            ptr_q[i] <= '0;
         end
      end else begin
         ready_q  <= ready_d;
         finish_q <= finish_d;
         ovf_q    <= ovf_d;
         len_q    <= len_d;
         cnt_q    <= cnt_d;
         g_q      <= g_d;
         cur_ok_q <= cur_ok_d;
         cur_r_q  <= cur_r_d;
         cur_k_q  <= cur_k_d;
         for (int unsigned i = 0; i < R_LEN; i++) begin
            r_q[i]   <= r_d[i];
            k_q[i]   <= k_d[i];
            ptr_q[i] <= ptr_d[i];
         end
      end
   end

   assign s_if.o_ready = ready_q;
   assign o_finish     = finish_q;
   assign o_overflow   = ovf_q;
   assign o_length     = len_q;
   assign o_groups     = g_q;
   assign o_r          = r_q;
   assign o_k          = k_q;
   assign o_ptr        = ptr_q;

endmodule

// File: tb/tb_weight_compressor.sv
// Directed bench for weight_compressor: hand-computed tables for each stream.
// Expectations follow WCOMP_KEEP_EMPTY_EN where the macro changes them.
module tb_weight_compressor;

   localparam int unsigned R_BW   = 4;
   localparam int unsigned K_BW   = 4;
   localparam int unsigned PTR_BW = 4;
   localparam int unsigned R_LEN  = 8;
   localparam int unsigned C_LEN  = 16;

   logic clk;
   logic rst_n;
   logic start;
   logic [R_BW-1:0]          o_r   [R_LEN];
   logic [K_BW-1:0]          o_k   [R_LEN];
   logic [PTR_BW:0]          o_ptr [R_LEN];
   logic [$clog2(C_LEN):0]   o_length;
   logic [$clog2(R_LEN):0]   o_groups;
   logic                     o_overflow;
   logic                     o_finish;

   int n_checks = 0;
   int n_fail   = 0;
   int fin_cnt  = 0;
   int fin_base;

   weight_compressor_if #(.R_BW(R_BW), .K_BW(K_BW)) s_if ();

   weight_compressor #(
      .R_BW(R_BW), .K_BW(K_BW), .PTR_BW(PTR_BW), .R_LEN(R_LEN), .C_LEN(C_LEN)
   ) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_start    (start),
      .s_if       (s_if.slave),
      .o_r        (o_r),
      .o_k        (o_k),
      .o_ptr      (o_ptr),
      .o_length   (o_length),
      .o_groups   (o_groups),
      .o_overflow (o_overflow),
      .o_finish   (o_finish)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // finish pulses are counted at the falling edge, away from the active edge
   always @(negedge clk) if (o_finish) fin_cnt <= fin_cnt + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic send(input logic [R_BW-1:0] r, input logic [K_BW-1:0] k,
                       input logic nz, input logic last);
      s_if.i_valid = 1'b1;
      s_if.i_r     = r;
      s_if.i_k     = k;
      s_if.i_nz    = nz;
      s_if.i_last  = last;
      @(posedge clk); #1;
      s_if.i_valid = 1'b0;
      s_if.i_nz    = 1'b0;
      s_if.i_last  = 1'b0;
   endtask

   initial begin
      start        = 1'b0;
      rst_n        = 1'b0;
      s_if.i_valid = 1'b0;
      s_if.i_last  = 1'b0;
      s_if.i_nz    = 1'b0;
      s_if.i_r     = '0;
      s_if.i_k     = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready",    32'(s_if.o_ready), 32'd0);
      check("rst_finish",   32'(o_finish),     32'd0);
      check("rst_length",   32'(o_length),     32'd0);
      check("rst_groups",   32'(o_groups),     32'd0);
      check("rst_overflow", 32'(o_overflow),   32'd0);
      check("rst_ptr1",     32'(o_ptr[1]),     32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // basic stream
      fin_base = fin_cnt;
      pulse_start();
      check("basic_ready", 32'(s_if.o_ready), 32'd1);
      send(4'd0, 4'd0, 1'b1, 1'b0);
      send(4'd0, 4'd0, 1'b1, 1'b0);
      send(4'd0, 4'd1, 1'b0, 1'b0);
      send(4'd1, 4'd2, 1'b1, 1'b0);
      check("basic_nofin", 32'(o_finish), 32'd0);
      send(4'd1, 4'd2, 1'b1, 1'b1);
      check("basic_finish", 32'(o_finish), 32'd1);
      check("basic_length", 32'(o_length), 32'd4);
      check("basic_r0",     32'(o_r[0]),   32'd0);
      check("basic_k0",     32'(o_k[0]),   32'd0);
      check("basic_ptr0",   32'(o_ptr[0]), 32'd0);
      check("basic_ptr1",   32'(o_ptr[1]), 32'd2);
`ifdef WCOMP_KEEP_EMPTY_EN
      check("basic_groups", 32'(o_groups), 32'd3);
      check("basic_r1",     32'(o_r[1]),   32'd0);
      check("basic_k1",     32'(o_k[1]),   32'd1);
      check("basic_ptr2",   32'(o_ptr[2]), 32'd2);
      check("basic_r2",     32'(o_r[2]),   32'd1);
      check("basic_k2",     32'(o_k[2]),   32'd2);
      check("basic_ptr3",   32'(o_ptr[3]), 32'd4);
`else
      check("basic_groups", 32'(o_groups), 32'd2);
      check("basic_r1",     32'(o_r[1]),   32'd1);
      check("basic_k1",     32'(o_k[1]),   32'd2);
      check("basic_ptr2",   32'(o_ptr[2]), 32'd4);
      check("basic_ptr3",   32'(o_ptr[3]), 32'd0);
`endif
      check("basic_ovf", 32'(o_overflow), 32'd0);
      @(posedge clk); #1;
      check("basic_fin_pulse", 32'(o_finish),     32'd0);
      check("basic_ready_off", 32'(s_if.o_ready), 32'd0);
      check("basic_fin_count", 32'(fin_cnt - fin_base), 32'd1);

      // single element, finish two cycles after start
      pulse_start();
      send(4'd3, 4'd5, 1'b1, 1'b1);
      check("single_finish", 32'(o_finish), 32'd1);
      check("single_r0",     32'(o_r[0]),   32'd3);
      check("single_k0",     32'(o_k[0]),   32'd5);
      check("single_ptr1",   32'(o_ptr[1]), 32'd1);
      check("single_cleared",32'(o_ptr[2]), 32'd0);
      check("single_groups", 32'(o_groups), 32'd1);
      @(posedge clk); #1;

      // group overflow: R_LEN distinct tags
      pulse_start();
      for (int i = 0; i < int'(R_LEN); i++)
         send(R_BW'(i), 4'd0, 1'b1, (i == int'(R_LEN) - 1));
      check("govf_groups", 32'(o_groups),         32'(R_LEN - 1));
      check("govf_flag",   32'(o_overflow),       32'd1);
      check("govf_length", 32'(o_length),         32'(R_LEN));
      check("govf_ptrmax", 32'(o_ptr[R_LEN - 1]), 32'(R_LEN - 1));
      check("govf_r6",     32'(o_r[R_LEN - 2]),   32'(R_LEN - 2));
      check("govf_ptr0",   32'(o_ptr[0]),         32'd0);
      @(posedge clk); #1;

      // count overflow: C_LEN+1 nonzeros in one group
      pulse_start();
      for (int i = 0; i <= int'(C_LEN); i++)
         send(4'd1, 4'd1, 1'b1, (i == int'(C_LEN)));
      check("covf_length", 32'(o_length),   32'(C_LEN));
      check("covf_flag",   32'(o_overflow), 32'd1);
      check("covf_ptr1",   32'(o_ptr[1]),   32'(C_LEN));
      check("covf_groups", 32'(o_groups),   32'd1);
      @(posedge clk); #1;

      // restart mid-run
      fin_base = fin_cnt;
      pulse_start();
      send(4'd0, 4'd0, 1'b1, 1'b0);
      send(4'd0, 4'd0, 1'b1, 1'b0);
      send(4'd1, 4'd1, 1'b1, 1'b0);
      pulse_start();
      check("rs_ready",  32'(s_if.o_ready), 32'd1);
      check("rs_length", 32'(o_length),     32'd0);
      send(4'd2, 4'd2, 1'b1, 1'b1);
      @(posedge clk); #1;
      check("rs_fin_count", 32'(fin_cnt - fin_base), 32'd1);
      check("rs_length2",   32'(o_length), 32'd1);
      check("rs_groups",    32'(o_groups), 32'd1);
      check("rs_r0",        32'(o_r[0]),   32'd2);
      check("rs_ptr1",      32'(o_ptr[1]), 32'd1);
      check("rs_ovf",       32'(o_overflow), 32'd0);

      // reset mid-run
      fin_base = fin_cnt;
      pulse_start();
      send(4'd1, 4'd1, 1'b1, 1'b0);
      send(4'd2, 4'd1, 1'b1, 1'b0);
      rst_n = 1'b0;
      #2;
      check("mr_ready",  32'(s_if.o_ready), 32'd0);
      check("mr_length", 32'(o_length),     32'd0);
      check("mr_groups", 32'(o_groups),     32'd0);
      check("mr_r0",     32'(o_r[0]),       32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      send(4'd3, 4'd3, 1'b1, 1'b0);
      send(4'd3, 4'd3, 1'b1, 1'b1);
      @(posedge clk); #1;
      check("mr_ready_idle", 32'(s_if.o_ready), 32'd0);
      check("mr_length_idle",32'(o_length),     32'd0);
      check("mr_fin_count",  32'(fin_cnt - fin_base), 32'd0);

      // start together with valid in idle: element dropped
      s_if.i_valid = 1'b1;
      s_if.i_r     = 4'd9;
      s_if.i_k     = 4'd9;
      s_if.i_nz    = 1'b1;
      pulse_start();
      s_if.i_valid = 1'b0;
      s_if.i_nz    = 1'b0;
      check("sv_length", 32'(o_length), 32'd0);
      send(4'd4, 4'd4, 1'b1, 1'b1);
      check("sv_length2", 32'(o_length), 32'd1);
      check("sv_r0",      32'(o_r[0]),   32'd4);
      check("sv_k0",      32'(o_k[0]),   32'd4);
      check("sv_finish",  32'(o_finish), 32'd1);
      @(posedge clk); #1;

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
